// File: rtl/maindec_pipe_if.sv
// ID-to-EX decode interface for maindec_pipe.
// The master drives the ID-stage instruction and the EX controls; the slave returns the EX bundle.
interface maindec_pipe_if;
    logic [31:0] instrD;
    logic        validD;
    logic        stallE;
    logic        flushE;
    logic        stallD;
    logic        validE;
    logic        regwriteE;
    logic [1:0]  regdstE;
    logic        alusrcE;
    logic        branchE;
    logic        storeE;
    logic        memtoregE;
    logic        jumpE;
    logic [2:0]  memopE;
    logic        hilowriteE;
    logic        jbalE;
    logic [1:0]  jumpopE;
    logic [4:0]  writeregE;
    logic        riE;
    logic        mdu_busy;

    modport master (
        output instrD, validD, stallE, flushE,
        input  stallD, validE, regwriteE, regdstE, alusrcE, branchE,
        input  storeE, memtoregE, jumpE, memopE, hilowriteE, jbalE,
        input  jumpopE, writeregE, riE, mdu_busy
    );

    modport slave (
        input  instrD, validD, stallE, flushE,
        output stallD, validE, regwriteE, regdstE, alusrcE, branchE,
        output storeE, memtoregE, jumpE, memopE, hilowriteE, jbalE,
        output jumpopE, writeregE, riE, mdu_busy
    );
endinterface

// File: rtl/maindec_pipe.sv
// Registered main decoder: decodes the ID instruction into the ID/EX control slot,
// with load-use and multiply/divide occupancy hazard stalls.
module maindec_pipe #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 32,
    parameter bit EN_RI      = 1'b1
) (
    input  logic           clk,
    input  logic           resetn,
    maindec_pipe_if.slave  bus
);

    localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef struct packed {
        logic       regwrite;
        logic [1:0] regdst;
        logic       alusrc;
        logic       branch;
        logic       store;
        logic       memtoreg;
        logic       jump;
        logic [2:0] memop;
        logic       hilowrite;
        logic       jbal;
        logic [1:0] jumpop;
        logic       ri;
    } ctl_t;

    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        unused_shamt;

    assign instr        = bus.instrD;
    assign op           = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign funct        = instr[5:0];
    assign unused_shamt = ^instr[10:6];

    ctl_t        dec;
    logic [4:0]  dec_wreg;
    logic        is_mul;
    logic        is_div;
    logic        hilo_use;
    logic        uses_rt;

    ctl_t        ctl_q, ctl_d;
    logic        valid_q, valid_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        load;
    logic        busy;
    logic        lu_haz;
    logic        mdu_haz;

    // Decode the ID instruction into a control bundle and hazard classes.
    always_comb begin
        dec      = '0;
        is_mul   = 1'b0;
        is_div   = 1'b0;
        hilo_use = 1'b0;
        uses_rt  = 1'b0;
        case (op)
            6'h00: begin
                uses_rt = 1'b1;
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2a, 6'h2b: begin
                        dec.regwrite = 1'b1;
                        dec.regdst   = 2'b01;
                    end
                    6'h10, 6'h12: begin
                        dec.regwrite = 1'b1;
                        dec.regdst   = 2'b01;
                        hilo_use     = 1'b1;
                    end
                    6'h11, 6'h13: begin
                        dec.hilowrite = 1'b1;
                        hilo_use      = 1'b1;
                    end
                    6'h18, 6'h19: begin
                        dec.hilowrite = 1'b1;
                        hilo_use      = 1'b1;
                        is_mul        = 1'b1;
                    end
                    6'h1a, 6'h1b: begin
                        dec.hilowrite = 1'b1;
                        hilo_use      = 1'b1;
                        is_div        = 1'b1;
                    end
                    6'h08: begin
                        dec.jump   = 1'b1;
                        dec.jumpop = 2'b10;
                    end
                    6'h09: begin
                        dec.regwrite = 1'b1;
                        dec.regdst   = 2'b01;
                        dec.jump     = 1'b1;
                        dec.jbal     = 1'b1;
                        dec.jumpop   = 2'b11;
                    end
                    default: dec.ri = 1'b1;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'b00000, 5'b00001: dec.branch = 1'b1;
                    5'b10000, 5'b10001: begin
                        dec.branch   = 1'b1;
                        dec.regwrite = 1'b1;
                        dec.regdst   = 2'b10;
                        dec.jbal     = 1'b1;
                    end
                    default: dec.ri = 1'b1;
                endcase
            end
            6'h02: begin
                dec.jump   = 1'b1;
                dec.jumpop = 2'b01;
            end
            6'h03: begin
                dec.jump     = 1'b1;
                dec.regwrite = 1'b1;
                dec.regdst   = 2'b10;
                dec.jbal     = 1'b1;
                dec.jumpop   = 2'b01;
            end
            6'h04, 6'h05: begin
                dec.branch = 1'b1;
                uses_rt    = 1'b1;
            end
            6'h06, 6'h07: dec.branch = 1'b1;
            6'h08, 6'h09, 6'h0a, 6'h0b,
            6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
            end
            6'h23, 6'h21, 6'h25, 6'h20, 6'h24: begin
                dec.regwrite = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memtoreg = 1'b1;
                case (op)
                    6'h21:   dec.memop = 3'b001;
                    6'h25:   dec.memop = 3'b010;
                    6'h20:   dec.memop = 3'b011;
                    6'h24:   dec.memop = 3'b100;
                    default: dec.memop = 3'b000;
                endcase
            end
            6'h28, 6'h29, 6'h2b: begin
                dec.alusrc = 1'b1;
                dec.store  = 1'b1;
                uses_rt    = 1'b1;
                case (op)
                    6'h28:   dec.memop = 3'b101;
                    6'h29:   dec.memop = 3'b110;
                    default: dec.memop = 3'b111;
                endcase
            end
            default: dec.ri = 1'b1;
        endcase
        if (!EN_RI) begin
            dec.ri = 1'b0;
        end
    end

    // Resolve the destination register; non-writing instructions report r0.
    always_comb begin
        dec_wreg = 5'd0;
        case (dec.regdst)
            2'b00:   dec_wreg = rt;
            2'b01:   dec_wreg = rd;
            2'b10:   dec_wreg = 5'd31;
            default: dec_wreg = 5'd0;
        endcase
        if (!dec.regwrite) begin
            dec_wreg = 5'd0;
        end
    end

    assign busy = (cnt_q != '0);

    // Hazards look only at ID inputs and registered EX state, never at next-state.
    always_comb begin
        lu_haz = bus.validD & valid_q & ctl_q.memtoreg & (wreg_q != 5'd0) &
                 ((wreg_q == rs) | (uses_rt & (wreg_q == rt)));
        mdu_haz = bus.validD & busy & hilo_use;
    end

    assign bus.stallD = bus.stallE | lu_haz | mdu_haz;

    // EX slot next state: flush, then hold, then bubble, then load.
    always_comb begin
        valid_d = valid_q;
        ctl_d   = ctl_q;
        wreg_d  = wreg_q;
        load    = 1'b0;
        if (bus.flushE) begin
            valid_d = 1'b0;
            ctl_d   = '0;
            wreg_d  = 5'd0;
        end else if (bus.stallE) begin
            valid_d = valid_q;
        end else if (!bus.validD || lu_haz || mdu_haz) begin
            valid_d = 1'b0;
            ctl_d   = '0;
            wreg_d  = 5'd0;
        end else begin
            valid_d = 1'b1;
            ctl_d   = dec;
            wreg_d  = dec_wreg;
            load    = 1'b1;
        end
    end

    // MDU occupancy: only a real load of MULT/DIV starts a count; flush cannot cancel it.
    always_comb begin
        cnt_d = cnt_q;
        if (load && is_mul) begin
            cnt_d = CW'(MUL_CYCLES);
        end else if (load && is_div) begin
            cnt_d = CW'(DIV_CYCLES);
        end else if (busy) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // ID/EX slot and MDU counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            ctl_q   <= '0;
            wreg_q  <= 5'd0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctl_q   <= ctl_d;
            wreg_q  <= wreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.validE     = valid_q;
    assign bus.regwriteE  = ctl_q.regwrite;
    assign bus.regdstE    = ctl_q.regdst;
    assign bus.alusrcE    = ctl_q.alusrc;
    assign bus.branchE    = ctl_q.branch;
    assign bus.storeE     = ctl_q.store;
    assign bus.memtoregE  = ctl_q.memtoreg;
    assign bus.jumpE      = ctl_q.jump;
    assign bus.memopE     = ctl_q.memop;
    assign bus.hilowriteE = ctl_q.hilowrite;
    assign bus.jbalE      = ctl_q.jbal;
    assign bus.jumpopE    = ctl_q.jumpop;
    assign bus.writeregE  = wreg_q;
    assign bus.riE        = ctl_q.ri;
    assign bus.mdu_busy   = busy;

endmodule

// File: tb/tb_maindec_pipe.sv
// Directed scoreboard bench for maindec_pipe.
// Expected EX bundles are queued as stimulus is driven and checked at each edge.
module tb_maindec_pipe;

    logic clk;
    logic resetn;
    int   tests;
    int   fails;

    maindec_pipe_if if1 ();
    maindec_pipe_if if2 ();

    assign if2.instrD = if1.instrD;
    assign if2.validD = if1.validD;
    assign if2.stallE = if1.stallE;
    assign if2.flushE = if1.flushE;

    maindec_pipe #(
        .MUL_CYCLES(2),
        .DIV_CYCLES(4),
        .EN_RI(1'b1)
    ) u_dut (
        .clk(clk),
        .resetn(resetn),
        .bus(if1)
    );

    maindec_pipe #(
        .MUL_CYCLES(2),
        .DIV_CYCLES(4),
        .EN_RI(1'b0)
    ) u_dut_nori (
        .clk(clk),
        .resetn(resetn),
        .bus(if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [21:0] exp_q[$];

    function automatic logic [21:0] bnd(
        bit rw, bit [1:0] rdst, bit as, bit br, bit st, bit mr, bit jp,
        bit [2:0] mo, bit hl, bit jb, bit [1:0] jo, bit [4:0] wr, bit ri);
        return {1'b1, rw, rdst, as, br, st, mr, jp, mo, hl, jb, jo, wr, ri};
    endfunction

    function automatic logic [21:0] obs();
        return {if1.validE, if1.regwriteE, if1.regdstE, if1.alusrcE,
                if1.branchE, if1.storeE, if1.memtoregE, if1.jumpE,
                if1.memopE, if1.hilowriteE, if1.jbalE, if1.jumpopE,
                if1.writeregE, if1.riE};
    endfunction

    function automatic logic [31:0] rt_i(logic [5:0] f);
        return {6'h00, 5'd7, 5'd6, 5'd5, 5'd0, f};
    endfunction

    function automatic logic [31:0] it_i(logic [5:0] op, logic [4:0] rt);
        return {op, 5'd7, rt, 16'h0010};
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic setin(logic vd, logic [31:0] ins);
        if1.validD = vd;
        if1.instrD = ins;
    endtask

    task automatic drv(logic vd, logic [31:0] ins, logic [21:0] e);
        setin(vd, ins);
        exp_q.push_back(e);
    endtask

    task automatic tick(string tag);
        logic [21:0] e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s got=empty exp=entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(obs()), 32'(e));
        end
    endtask

    task automatic sweep(string tag, logic [31:0] ins, logic [21:0] e);
        drv(1'b1, ins, e);
        tick(tag);
        drv(1'b0, 32'h0, 22'h0);
        tick({tag, "_gap"});
    endtask

    logic [21:0] alu5;
    logic [21:0] imm6;
    logic [21:0] brc;
    logic [21:0] hlw;
    logic [21:0] rib;
    logic [21:0] lnk;
    int          stalls;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests  = 0;
        fails  = 0;
        resetn = 1'b0;
        if1.instrD = 32'h0;
        if1.validD = 1'b0;
        if1.stallE = 1'b0;
        if1.flushE = 1'b0;

        alu5 = bnd(1, 2'b01, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00, 5'd5, 0);
        imm6 = bnd(1, 2'b00, 1, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00, 5'd6, 0);
        brc  = bnd(0, 2'b00, 0, 1, 0, 0, 0, 3'b000, 0, 0, 2'b00, 5'd0, 0);
        hlw  = bnd(0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 1, 0, 2'b00, 5'd0, 0);
        rib  = bnd(0, 2'b00, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00, 5'd0, 1);
        lnk  = bnd(1, 2'b10, 0, 1, 0, 0, 0, 3'b000, 0, 1, 2'b00, 5'd31, 0);

        #12;
        chk("rst_bundle", 32'(obs()), 32'h0);
        chk("rst_busy", 32'(if1.mdu_busy), 32'h0);
        #1 resetn = 1'b1;

        sweep("addu", rt_i(6'h21), alu5);
        sweep("sll", rt_i(6'h00), alu5);
        sweep("slt", rt_i(6'h2a), alu5);
        sweep("mfhi", rt_i(6'h10), alu5);
        sweep("mflo", rt_i(6'h12), alu5);
        sweep("mthi", rt_i(6'h11), hlw);
        sweep("mtlo", rt_i(6'h13), hlw);
        sweep("jr", rt_i(6'h08),
              bnd(0, 2'b00, 0, 0, 0, 0, 1, 3'b000, 0, 0, 2'b10, 5'd0, 0));
        sweep("jalr", rt_i(6'h09),
              bnd(1, 2'b01, 0, 0, 0, 0, 1, 3'b000, 0, 1, 2'b11, 5'd5, 0));
        sweep("syscall", rt_i(6'h0c), rib);
        sweep("addi", it_i(6'h08, 5'd6), imm6);
        sweep("sltiu", it_i(6'h0b, 5'd6), imm6);
        sweep("ori", it_i(6'h0d, 5'd6), imm6);
        sweep("lui", it_i(6'h0f, 5'd6), imm6);
        sweep("lw", it_i(6'h23, 5'd6),
              bnd(1, 2'b00, 1, 0, 0, 1, 0, 3'b000, 0, 0, 2'b00, 5'd6, 0));
        sweep("lh", it_i(6'h21, 5'd6),
              bnd(1, 2'b00, 1, 0, 0, 1, 0, 3'b001, 0, 0, 2'b00, 5'd6, 0));
        sweep("lhu", it_i(6'h25, 5'd6),
              bnd(1, 2'b00, 1, 0, 0, 1, 0, 3'b010, 0, 0, 2'b00, 5'd6, 0));
        sweep("lb", it_i(6'h20, 5'd6),
              bnd(1, 2'b00, 1, 0, 0, 1, 0, 3'b011, 0, 0, 2'b00, 5'd6, 0));
        sweep("lbu", it_i(6'h24, 5'd6),
              bnd(1, 2'b00, 1, 0, 0, 1, 0, 3'b100, 0, 0, 2'b00, 5'd6, 0));
        sweep("sb", it_i(6'h28, 5'd6),
              bnd(0, 2'b00, 1, 0, 1, 0, 0, 3'b101, 0, 0, 2'b00, 5'd0, 0));
        sweep("sh", it_i(6'h29, 5'd6),
              bnd(0, 2'b00, 1, 0, 1, 0, 0, 3'b110, 0, 0, 2'b00, 5'd0, 0));
        sweep("sw", it_i(6'h2b, 5'd6),
              bnd(0, 2'b00, 1, 0, 1, 0, 0, 3'b111, 0, 0, 2'b00, 5'd0, 0));
        sweep("beq", it_i(6'h04, 5'd6), brc);
        sweep("bne", it_i(6'h05, 5'd6), brc);
        sweep("blez", it_i(6'h06, 5'd0), brc);
        sweep("bgtz", it_i(6'h07, 5'd0), brc);
        sweep("bltz", it_i(6'h01, 5'd0), brc);
        sweep("bgez", it_i(6'h01, 5'd1), brc);
        sweep("bltzal", it_i(6'h01, 5'd16), lnk);
        sweep("bgezal", it_i(6'h01, 5'd17), lnk);
        sweep("regimm_rt2", it_i(6'h01, 5'd2), rib);
        sweep("j", {6'h02, 26'h10},
              bnd(0, 2'b00, 0, 0, 0, 0, 1, 3'b000, 0, 0, 2'b01, 5'd0, 0));
        sweep("jal", {6'h03, 26'h10},
              bnd(1, 2'b10, 0, 0, 0, 0, 1, 3'b000, 0, 1, 2'b01, 5'd31, 0));

        drv(1'b1, it_i(6'h3f, 5'd6), rib);
        tick("op3f_ri1");
        chk("op3f_ri0", 32'(if2.riE), 32'h0);
        chk("op3f_ri0_valid", 32'(if2.validE), 32'h1);
        drv(1'b0, 32'h0, 22'h0);
        tick("op3f_gap");

        drv(1'b1, {6'h23, 5'd7, 5'd8, 16'h0004},
            bnd(1, 2'b00, 1, 0, 0, 1, 0, 3'b000, 0, 0, 2'b00, 5'd8, 0));
        tick("lu_lw");
        setin(1'b1, {6'h00, 5'd8, 5'd2, 5'd9, 5'd0, 6'h21});
        #1 chk("lu_stall", 32'(if1.stallD), 32'h1);
        exp_q.push_back(22'h0);
        tick("lu_bubble");
        chk("lu_unstall", 32'(if1.stallD), 32'h0);
        exp_q.push_back(bnd(1, 2'b01, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00, 5'd9, 0));
        tick("lu_addu");
        drv(1'b1, {6'h23, 5'd7, 5'd8, 16'h0004},
            bnd(1, 2'b00, 1, 0, 0, 1, 0, 3'b000, 0, 0, 2'b00, 5'd8, 0));
        tick("lu_lw2");
        setin(1'b1, {6'h0f, 5'd0, 5'd8, 16'h1234});
        #1 chk("lu_lui_nostall", 32'(if1.stallD), 32'h0);
        exp_q.push_back(bnd(1, 2'b00, 1, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00, 5'd8, 0));
        tick("lu_lui");
        drv(1'b0, 32'h0, 22'h0);
        tick("lu_gap");

        drv(1'b1, rt_i(6'h1a), hlw);
        tick("div");
        chk("div_busy", 32'(if1.mdu_busy), 32'h1);
        setin(1'b1, rt_i(6'h12));
        stalls = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (!if1.stallD) break;
            stalls++;
            exp_q.push_back(22'h0);
            tick("div_wait");
        end
        chk("div_stalls", 32'(stalls), 32'd4);
        chk("div_idle", 32'(if1.mdu_busy), 32'h0);
        exp_q.push_back(alu5);
        tick("div_mflo");
        drv(1'b0, 32'h0, 22'h0);
        tick("div_gap");

        drv(1'b1, rt_i(6'h18), hlw);
        tick("mult");
        setin(1'b1, rt_i(6'h10));
        stalls = 0;
        for (int i = 0; i < 12; i++) begin
            #1;
            if (!if1.stallD) break;
            stalls++;
            exp_q.push_back(22'h0);
            tick("mult_wait");
        end
        chk("mult_stalls", 32'(stalls), 32'd2);
        exp_q.push_back(alu5);
        tick("mult_mfhi");
        drv(1'b0, 32'h0, 22'h0);
        tick("mult_gap");

        drv(1'b1, rt_i(6'h21), alu5);
        tick("ctl_addu");
        if1.stallE = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, it_i(6'h0d, 5'd6), alu5);
            #1 chk("ctl_stallD", 32'(if1.stallD), 32'h1);
            tick("ctl_hold");
        end
        if1.flushE = 1'b1;
        drv(1'b1, it_i(6'h0d, 5'd6), 22'h0);
        tick("ctl_flush_stall");
        if1.flushE = 1'b0;
        if1.stallE = 1'b0;
        drv(1'b0, 32'h0, 22'h0);
        tick("ctl_gap");

        drv(1'b1, rt_i(6'h1a), hlw);
        tick("rst_div");
        setin(1'b0, 32'h0);
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_bundle", 32'(obs()), 32'h0);
        chk("rst_async_busy", 32'(if1.mdu_busy), 32'h0);
        #1 resetn = 1'b1;
        drv(1'b0, 32'h0, 22'h0);
        tick("rst_edge1");
        chk("rst_busy_after", 32'(if1.mdu_busy), 32'h0);
        drv(1'b1, rt_i(6'h21), alu5);
        tick("rst_addu");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/maindec_pipe.md
# maindec_pipe

Parametrised, registered successor to the combinational main decoder. It decodes the ID-stage instruction word into the standard control bundle and registers that bundle into the ID/EX pipeline slot, with stall, flush and bubble insertion. It detects load-use hazards against the instruction held in EX. It tracks multi-cycle multiply/divide occupancy so that HI/LO consumers wait until the MDU is free.

## Interface
Parameters:
- MUL_CYCLES, default 2: busy cycles after a MULT/MULTU issues; minimum 1.
- DIV_CYCLES, default 32: busy cycles after a DIV/DIVU issues; minimum 1.
- EN_RI, default 1: 1 asserts riE for undecodable opcodes; 0 forces riE to 0.

Ports:
- clk, in, 1: single clock, rising edge.
- resetn, in, 1: asynchronous, active-low reset.
- instrD, in, 32: ID-stage instruction. op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], funct=[5:0].
- validD, in, 1: instrD holds a real instruction.
- stallE, in, 1: EX slot must hold its contents.
- flushE, in, 1: EX slot becomes a bubble.
- stallD, out, 1: ID must hold instrD (combinational).
- validE, out, 1: EX slot holds a real instruction.
- regwriteE, out, 1: instruction writes the register file.
- regdstE, out, 2: destination select. 00=rt, 01=rd, 10=r31.
- alusrcE, out, 1: ALU B operand is the immediate.
- branchE, out, 1: conditional branch.
- storeE, out, 1: store instruction (byte enables are generated downstream).
- memtoregE, out, 1: writeback data comes from memory.
- jumpE, out, 1: J, JAL, JR or JALR.
- memopE, out, 3: memory operation. 000=LW, 001=LH, 010=LHU, 011=LB, 100=LBU, 101=SB, 110=SH, 111=SW. Meaningful only when memtoregE or storeE is set.
- hilowriteE, out, 1: instruction writes HI and/or LO.
- jbalE, out, 1: link write of PC+8.
- jumpopE, out, 2: jump type. 01=J, 10=JR, 11=JALR/JAL-register form.
- writeregE, out, 5: resolved destination register. Forced to 0 when regwriteE=0.
- riE, out, 1: reserved-instruction flag.
- mdu_busy, out, 1: MDU occupancy counter is non-zero.

## Operation
- Decode truth set:
  - R-type ALU ops, MFHI/MFLO: regwrite, regdst=01.
  - MTHI/MTLO, MULT/MULTU/DIV/DIVU: hilowrite.
  - JR: jump, jumpop=10.
  - JALR: regwrite, regdst=01, jump, jbal, jumpop=11.
  - ADDI/ADDIU/ANDI/ORI/XORI/LUI/SLTI/SLTIU: regwrite, alusrc.
  - Loads: regwrite, alusrc, memtoreg, memop per the encoding above.
  - Stores: alusrc, store, memop per the encoding above.
  - BEQ/BNE/BGTZ/BLEZ, and REGIMM with rt=00000/00001: branch.
  - REGIMM with rt=10000/10001: branch, regwrite, regdst=10, jbal.
  - J: jump, jumpop=01.
  - JAL: jump, regwrite, regdst=10, jbal, jumpop=01.
  - Anything else: all controls 0, ri=1.
- Load-use hazard. Asserted when all hold: validD, validE, memtoregE, writeregE≠0, and either writeregE==rs or (writeregE==rt and the instruction uses rt). Instructions that use rt: op=0, BEQ, BNE, stores.
- MDU hazard. Asserted when validD, mdu_busy, and the ID instruction is one of MFHI, MFLO, MTHI, MTLO, MULT*, DIV*.
- stallD = stallE | load-use hazard | MDU hazard.
- EX slot update, in priority order:
  1. flushE: bubble.
  2. stallE: hold.
  3. !validD, load-use hazard, or MDU hazard: bubble.
  4. Otherwise: load the decoded bundle and set validE=1.
- A bubble has all outputs 0, including validE and riE.
- MDU counter, width clog2(max(MUL_CYCLES,DIV_CYCLES)+1):
  - On a load of MULT/MULTU: counter := MUL_CYCLES.
  - On a load of DIV/DIVU: counter := DIV_CYCLES.
  - Otherwise: decrement if non-zero; 0 saturates.
  - flushE of the EX slot does not cancel an already-loaded count.
  - A bubble or hold never starts a count.

## Timing
- resetn low: all E-stage outputs 0, counter 0, mdu_busy 0, immediately and independent of clk. Reset mid-division clears the counter.
- Latency: decoded bundle is visible on E outputs one clock after instrD is accepted.
- stallD and hazards are combinational from instrD, validD, the E registers and the counter. There are no combinational paths from the E outputs back into the E registers within the same cycle.
- mdu_busy rises the cycle after the MDU op loads into EX. It stays high exactly N cycles, where N is MUL_CYCLES or DIV_CYCLES.
- A HI/LO consumer behind a DIV enters EX on the first edge with counter==0.
- Simultaneous flushE and stallE: flush wins.
- Simultaneous hazard and stallE: EX holds; it does not bubble.

## Test plan
- Reset: drive resetn=0 mid-stream with a DIV in flight. All outputs read 0 asynchronously. After release, the first ADDU (rd=5) appears on the second edge with regwriteE=1, regdstE=01, writeregE=5.
- Load-use: LW r8 followed by ADDU r9,r8,r2. Exactly one bubble (validE=0) is inserted and stallD is high for 1 cycle. LW followed by LUI r8 produces no stall.
- MDU, DIV_CYCLES=4: DIV followed by MFLO. stallD is held 4 cycles, MFLO reaches EX 5 edges after the DIV. Repeat with MULT at MUL_CYCLES=2: MFHI is stalled 2 cycles.
- Control: stallE held 3 cycles freezes every E output. flushE together with stallE gives validE=0 on the next edge.
- Decode sweep: every listed opcode/funct/rt checked against its expected bundle. JAL gives writeregE=31, jbalE=1. SH gives memopE=110, storeE=1. op=6'b111111 gives riE=1 with EN_RI=1 and riE=0 with EN_RI=0.
- Sign/zero rule: REGIMM rt=00010 gives riE=1 and all controls 0. BLTZAL gives regwriteE=1, writeregE=31, branchE=1.
